mem_stage_module: RTL

- Memory-access pipeline stage directly downstream of the execute stage.
- Consumes the EX/MEM register outputs: memory controls, write-back controls, destination register, ALU result and store data (Rm).
- Drives a request/acknowledge data-memory port with variable wait states, and stalls the pipeline via `ready` while an access is outstanding.
- Registers the MEM/WB payload for the write-back stage.

---
 rtl/mem_stage_module.sv | 103 ++++++++++
 1 files changed

// File: rtl/mem_stage_module.sv
// Memory-access stage between EX/MEM and MEM/WB: issues one request/acknowledge
// data-memory access at a time and stalls upstream via ready until it completes.
module mem_stage_module #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 4,
   parameter int MEM_ADDR_W = 16,
   parameter int BASE_ADDR  = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_read_in,
   input  logic                  mem_write_in,
   input  logic                  wb_enable_in,
   input  logic [REG_ADDR_W-1:0] dest_reg_in,
   input  logic [DATA_W-1:0]     alu_result_in,
   input  logic [DATA_W-1:0]     store_data_in,
   output logic                  ready,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [MEM_ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic                  mem_ack,
   input  logic [DATA_W-1:0]     mem_rdata,
   output logic                  wb_enable_out,
   output logic                  mem_read_out,
   output logic [REG_ADDR_W-1:0] dest_reg_out,
   output logic [DATA_W-1:0]     alu_result_out,
   output logic [DATA_W-1:0]     mem_data_out
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state;
   logic              access_p0;
   logic              vld_p0;
   logic [DATA_W-1:0] rdata_p1;

   // Byte address relative to BASE_ADDR, turned into a word index; the low
   // two bits are dropped silently, so misaligned addresses are not flagged.
   function automatic logic [MEM_ADDR_W-1:0] word_addr(input logic [DATA_W-1:0] byte_addr);
      return MEM_ADDR_W'((byte_addr - DATA_W'(BASE_ADDR)) >> 2);
   endfunction

   assign access_p0 = mem_read_in | mem_write_in;
   assign vld_p0    = ((state == IDLE) && !access_p0) || (state == DONE);
   assign ready     = vld_p0;

   // Stage p0 -> p1: memory-port FSM and MEM/WB register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         mem_req        <= 1'b0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
         wb_enable_out  <= 1'b0;
         mem_read_out   <= 1'b0;
         dest_reg_out   <= '0;
         alu_result_out <= '0;
         mem_data_out   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (access_p0) begin
                  state     <= BUSY;
                  mem_req   <= 1'b1;
                  mem_we    <= mem_write_in;
                  mem_addr  <= word_addr(alu_result_in);
                  mem_wdata <= store_data_in;
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  state   <= DONE;
                  mem_req <= 1'b0;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase

         if (vld_p0) begin
            wb_enable_out  <= wb_enable_in;
            mem_read_out   <= mem_read_in;
            dest_reg_out   <= dest_reg_in;
            alu_result_out <= alu_result_in;
            // Stores leave the previous load data in place.
            if ((state == DONE) && !mem_we)
               mem_data_out <= rdata_p1;
         end else begin
            wb_enable_out <= 1'b0;
            mem_read_out  <= 1'b0;
         end
      end
   end

   // Load data buffer: only the acknowledged read beat is kept.
   always_ff @(posedge clk) begin
      if ((state == BUSY) && mem_ack && !mem_we)
         rdata_p1 <= mem_rdata;
   end

endmodule
